// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding and latency constants shared by the sequencer and its bench.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, CAPTURE} state_t;
    function automatic int feed_len(input int n);
        return n;
    endfunction
    function automatic int flush_len(input int n);
        return 2 * n - 2;
    endfunction
    function automatic int total_len(input int n);
        return 3 * n;
    endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage delay line used to skew one systolic feed lane; DEPTH=0 is a wire.
module skew_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_reg
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
            end else begin
                sr[0] <= din;
                for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
            end
        assign dout = sr[DEPTH-1];
    end
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: feeds skewed A rows / B columns into an N x N systolic array and captures its result.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_acc,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    input  logic [W*N*N-1:0] i_C,
    output logic [W*N-1:0]   o_A,
    output logic [W*N-1:0]   o_B,
    output logic             o_en,
    output logic             o_sync,
    output logic             o_busy,
    output logic             o_done,
    output logic [W*N*N-1:0] o_C
);
    localparam int FEED_LEN  = feed_len(N);
    localparam int FLUSH_LEN = flush_len(N);
    localparam int CW        = $clog2(total_len(N));

    state_t          state, state_n;
    logic [CW-1:0]   k, k_n;
    logic [W*N*N-1:0] a_q, b_q;
    logic            acc_q;
    logic [W-1:0]    row [N];
    logic [W-1:0]    col [N];

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end

    always_comb begin
        state_n = state;
        k_n     = k;
        o_en    = (state == FEED) || (state == FLUSH);
        o_sync  = (state == FEED) && (k == '0) && !acc_q;
        o_busy  = state != IDLE;
        unique case (state)
            IDLE: if (i_start) begin
                state_n = FEED;
                k_n     = '0;
            end
            FEED: if (k == CW'(FEED_LEN - 1)) begin
                state_n = FLUSH;
                k_n     = '0;
            end else k_n = k + 1'b1;
            FLUSH: if (k == CW'(FLUSH_LEN - 1)) begin
                state_n = CAPTURE;
                k_n     = '0;
            end else k_n = k + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= 1'b0;
            o_C    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= state == CAPTURE;
            if (state == CAPTURE) o_C <= i_C;
            if (state == IDLE && i_start) begin
                a_q   <= i_A;
                b_q   <= i_B;
                acc_q <= i_acc;
            end
        end

    // Unskewed feed: column k of A into the row lanes, row k of B into the column lanes.
    always_comb
        for (int r = 0; r < N; r++) begin
            row[r] = (state == FEED) ? a_q[(r * N + int'(k)) * W +: W] : '0;
            col[r] = (state == FEED) ? b_q[(int'(k) * N + r) * W +: W] : '0;
        end

    assign o_A[W-1:0] = row[0];
    assign o_B[W-1:0] = col[0];

    for (genvar i = 1; i < N; i++) begin : g_skew
        skew_line #(.WIDTH(W), .DEPTH(i)) u_a (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .din  (row[i]),
            .dout (o_A[i*W +: W])
        );
        skew_line #(.WIDTH(W), .DEPTH(i)) u_b (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .din  (col[i]),
            .dout (o_B[i*W +: W])
        );
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed checks of feed skew, timing, accumulate, reset and back-to-back behaviour.
module tb_systolic_sequencer;
    localparam int W  = 32;
    localparam int N  = 3;
    localparam int M  = W * N * N;
    localparam int W4 = 8;
    localparam int N4 = 4;
    localparam int M4 = W4 * N4 * N4;

    logic clk = 1'b0;
    logic rst_n, start, acc, start4;
    logic [M-1:0] a_in, b_in, c_in, o_C;
    logic [W*N-1:0] o_A, o_B;
    logic o_en, o_sync, o_busy, o_done;
    logic [M4-1:0] a4, b4, c4, o_C4;
    logic [W4*N4-1:0] o_A4, o_B4;
    logic o_en4, o_sync4, o_busy4, o_done4;
    logic [M-1:0] A1, B1, A2, B2, C1, C2, C3;
    int n_cmp = 0;
    int n_err = 0;
    int t;

    always #5 clk = ~clk;

    systolic_sequencer #(.W(W), .N(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_acc(acc),
        .i_A(a_in), .i_B(b_in), .i_C(c_in),
        .o_A(o_A), .o_B(o_B), .o_en(o_en), .o_sync(o_sync),
        .o_busy(o_busy), .o_done(o_done), .o_C(o_C)
    );

    systolic_sequencer #(.W(W4), .N(N4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_acc(1'b0),
        .i_A(a4), .i_B(b4), .i_C(c4),
        .o_A(o_A4), .o_B(o_B4), .o_en(o_en4), .o_sync(o_sync4),
        .o_busy(o_busy4), .o_done(o_done4), .o_C(o_C4)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference array: result = c0 + a*b, element-wise wrap to W bits.
    function automatic logic [M-1:0] matmul(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic [M-1:0] c0);
        logic [M-1:0] m;
        logic [W-1:0] s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = c0[(r*N+c)*W +: W];
                for (int j = 0; j < N; j++) s += a[(r*N+j)*W +: W] * b[(j*N+c)*W +: W];
                m[(r*N+c)*W +: W] = s;
            end
        return m;
    endfunction

    // Expected lane values t cycles after the start was sampled.
    function automatic logic [W*N-1:0] lanes(input logic [M-1:0] m, input int tt, input bit is_row);
        logic [W*N-1:0] v;
        int s;
        v = '0;
        for (int l = 0; l < N; l++) begin
            s = tt - 1 - l;
            if (s >= 0 && s < N)
                v[l*W +: W] = is_row ? m[(l*N+s)*W +: W] : m[(s*N+l)*W +: W];
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; acc = 1'b0; start4 = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; a4 = '0; b4 = '0; c4 = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                A1[(r*N+c)*W +: W] = 32'(r * N + c + 1);
                B1[(r*N+c)*W +: W] = (r == c) ? 32'd1 : 32'd0;
                A2[(r*N+c)*W +: W] = 32'hF000_0000 | 32'(r * N + c);
                B2[(r*N+c)*W +: W] = 32'(r + 2 * c + 1);
            end
        C1 = matmul(A1, B1, '0);
        C2 = matmul(A2, B2, C1);
        C3 = matmul(A1, B2, '0);
        step;
        step;
        chk("rst_oA", o_A, '0);
        chk("rst_oB", o_B, '0);
        chk("rst_en", o_en, 1'b0);
        chk("rst_sync", o_sync, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_oC", o_C, '0);
        chk("rst_busy4", o_busy4, 1'b0);
        // op1 starts on the edge that also releases reset; op2 back-to-back with accumulate
        rst_n = 1'b1; start = 1'b1; acc = 1'b0; a_in = A1; b_in = B1; c_in = C1;
        for (int c = 1; c <= 18; c++) begin
            step;
            t = (c - 1) % 9 + 1;
            chk("en", o_en, t <= 7);
            chk("sync", o_sync, t == 1 && c < 9);
            chk("busy", o_busy, t <= 8);
            chk("done", o_done, t == 9);
            chk("oA", o_A, lanes(c > 9 ? A2 : A1, t, 1'b1));
            chk("oB", o_B, lanes(c > 9 ? B2 : B1, t, 1'b0));
            if (c == 3) begin
                chk("oA_lane2_c3", o_A[95:64], 32'd7);
                chk("oB_lane1_c3", o_B[63:32], 32'd1);
            end
            if (c == 8) chk("oC_pre", o_C, '0);
            if (c == 9) begin
                chk("oC1", o_C, C1);
                chk("oC1_e00", o_C[31:0], 32'd1);
                chk("oC1_e22", o_C[287:256], 32'd9);
            end
            if (c == 17) chk("oC_hold", o_C, C1);
            if (c == 18) chk("oC2", o_C, C2);
            start = (c == 4) || (c == 9);
            if (c == 1) a_in = ~A1;
            if (c == 4) b_in = ~B1;
            if (c == 9) begin
                a_in = A2; b_in = B2; acc = 1'b1; c_in = C2;
            end
        end
        // op3 accepted in op2's done cycle, then abandoned by reset
        start = 1'b1; acc = 1'b0; a_in = A1; b_in = B2; c_in = C3;
        for (int c = 1; c <= 5; c++) begin
            step;
            chk("op3_busy", o_busy, 1'b1);
            chk("op3_sync", o_sync, c == 1);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_oA", o_A, '0);
        chk("mid_oB", o_B, '0);
        chk("mid_en", o_en, 1'b0);
        chk("mid_sync", o_sync, 1'b0);
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_done", o_done, 1'b0);
        chk("mid_oC", o_C, '0);
        step;
        chk("rst_hold_done", o_done, 1'b0);
        rst_n = 1'b1; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step;
            chk("post_en", o_en, c <= 7);
            chk("post_sync", o_sync, c == 1);
            chk("post_busy", o_busy, c <= 8);
            chk("post_done", o_done, c == 9);
            if (c == 9) chk("post_oC", o_C, C3);
            start = 1'b0;
        end
        // N=4: start held high continuously, one op per 12 cycles
        a4 = {16{8'h5A}}; b4 = {16{8'hC3}}; c4 = {8{16'hBEEF}}; start4 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step;
            t = (c - 1) % 12 + 1;
            chk("n4_en", o_en4, t <= 10);
            chk("n4_sync", o_sync4, t == 1);
            chk("n4_busy", o_busy4, t <= 11);
            chk("n4_done", o_done4, t == 12);
            if (c == 12) chk("n4_oC", o_C4, {8{16'hBEEF}});
        end
        start4 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
